// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants and coordinate types for the VGA raster path.
//   The default values describe 640x480 @ 60 Hz on a 25.175 MHz pixel clock.
//   The coordinate typedefs are also used by the pixel-colour stage.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int XW = 11;
  localparam int YW = 10;

  typedef logic [XW-1:0] xpos_t;
  typedef logic [YW-1:0] ypos_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   Modulo-TOTAL up-counter for one raster axis.
//   Ports:
//     clk   - pixel clock
//     reset - asynchronous, active-high reset (count returns to 0)
//     en    - advance the count this cycle
//     cnt   - current count, 0..TOTAL-1
//     wrap  - high on the enabled cycle where cnt is TOTAL-1 (next count is 0)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = DEF_H_TOTAL,
  parameter int W     = XW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign wrap = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running VGA raster timing generator. Each axis runs
//   visible -> front porch -> sync -> back porch, with (0,0) being the first
//   visible pixel. All outputs are registered from the decode of the counter
//   values before the edge, so they are mutually aligned and trail the
//   internal counters by one cycle.
//   Ports:
//     vga_clk     - pixel clock
//     reset       - asynchronous, active-high reset
//     blank_n     - 1 during an active video pixel
//     HS, VS      - horizontal / vertical sync
//     xPos, yPos  - raster coordinates of the current output pixel
//     line_start  - one-cycle pulse when xPos == 0
//     frame_start - one-cycle pulse when xPos == 0 and yPos == 0
//   Build option:
//     VGA_SYNC_POS_EN - when defined, HS/VS are active-high (idle/reset 0);
//                       otherwise they are active-low (idle/reset 1).
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic          vga_clk,
  input  logic          reset,
  output logic          blank_n,
  output logic          HS,
  output logic          VS,
  output logic [XW-1:0] xPos,
  output logic [YW-1:0] yPos,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 2048) begin : g_h_total_chk
    $error("vga_timing_gen: H_TOTAL exceeds 2048");
  end
  if (V_TOTAL > 1024) begin : g_v_total_chk
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end

`ifdef VGA_SYNC_POS_EN
  localparam logic SYNC_ACT = 1'b1;
`else
  localparam logic SYNC_ACT = 1'b0;
`endif

  localparam logic [XW-1:0] H_VIS_END    = XW'(H_VISIBLE);
  localparam logic [XW-1:0] H_SYNC_FIRST = XW'(H_VISIBLE + H_FRONT);
  localparam logic [XW-1:0] H_SYNC_LAST  = XW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [YW-1:0] V_VIS_END    = YW'(V_VISIBLE);
  localparam logic [YW-1:0] V_SYNC_FIRST = YW'(V_VISIBLE + V_FRONT);
  localparam logic [YW-1:0] V_SYNC_LAST  = YW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  xpos_t h_cnt;
  ypos_t v_cnt;
  logic  h_wrap;
  logic  v_wrap_unused;

  vga_axis_counter #(.TOTAL(H_TOTAL), .W(XW)) u_h_cnt (
    .clk   (vga_clk),
    .reset (reset),
    .en    (1'b1),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .W(YW)) u_v_cnt (
    .clk   (vga_clk),
    .reset (reset),
    .en    (h_wrap),
    .cnt   (v_cnt),
    .wrap  (v_wrap_unused)
  );

  logic  blank_n_d, hs_d, vs_d, line_start_d, frame_start_d;
  logic  blank_n_q, hs_q, vs_q, line_start_q, frame_start_q;
  xpos_t x_q;
  ypos_t y_q;

  always_comb begin
    blank_n_d     = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    hs_d          = ((h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST)) ? SYNC_ACT : ~SYNC_ACT;
    vs_d          = ((v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST)) ? SYNC_ACT : ~SYNC_ACT;
    line_start_d  = (h_cnt == '0);
    frame_start_d = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blank_n_q     <= 1'b0;
      hs_q          <= ~SYNC_ACT;
      vs_q          <= ~SYNC_ACT;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      blank_n_q     <= blank_n_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      x_q           <= h_cnt;
      y_q           <= v_cnt;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign blank_n     = blank_n_q;
  assign HS          = hs_q;
  assign VS          = vs_q;
  assign xPos        = x_q;
  assign yPos        = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Directed bench for vga_timing_gen. A default-timing instance covers reset,
//   line-level horizontal timing and asynchronous reset; a small-timing
//   instance (H 8/2/2/2, V 4/1/1/1) covers whole frames, vertical sync and wrap.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_POS_EN
  localparam logic ACT = 1'b1;
`else
  localparam logic ACT = 1'b0;
`endif
  localparam logic IDLE = ~ACT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   = 1'b1;
  logic        rst_s = 1'b1;

  logic        b_blank, b_hs, b_vs, b_ls, b_fs;
  logic [10:0] b_x;
  logic [9:0]  b_y;
  logic        s_blank, s_hs, s_vs, s_ls, s_fs;
  logic [10:0] s_x;
  logic [9:0]  s_y;

  int checks   = 0;
  int failures = 0;

  vga_timing_gen u_dut (
    .vga_clk     (clk),
    .reset       (rst),
    .blank_n     (b_blank),
    .HS          (b_hs),
    .VS          (b_vs),
    .xPos        (b_x),
    .yPos        (b_y),
    .line_start  (b_ls),
    .frame_start (b_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (
    .vga_clk     (clk),
    .reset       (rst_s),
    .blank_n     (s_blank),
    .HS          (s_hs),
    .VS          (s_vs),
    .xPos        (s_x),
    .yPos        (s_y),
    .line_start  (s_ls),
    .frame_start (s_fs)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (b_blank !== 1'b0) begin failures++; $display("FAIL reset_blank_n got=%0b exp=0", b_blank); end
    checks++; if (b_hs !== IDLE) begin failures++; $display("FAIL reset_hs got=%0b exp=%0b", b_hs, IDLE); end
    checks++; if (b_vs !== IDLE) begin failures++; $display("FAIL reset_vs got=%0b exp=%0b", b_vs, IDLE); end
    checks++; if (b_x !== 11'd0 || b_y !== 10'd0) begin failures++; $display("FAIL reset_xy got=(%0d,%0d) exp=(0,0)", b_x, b_y); end
    checks++; if (b_ls !== 1'b0 || b_fs !== 1'b0) begin failures++; $display("FAIL reset_strobes got=ls%0b fs%0b exp=0 0", b_ls, b_fs); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (b_blank !== 1'b0) begin failures++; $display("FAIL pre_edge_blank_n got=%0b exp=0", b_blank); end
    @(posedge clk);
    #1;
    checks++; if (b_x !== 11'd0 || b_y !== 10'd0) begin failures++; $display("FAIL first_edge_xy got=(%0d,%0d) exp=(0,0)", b_x, b_y); end
    checks++; if (b_blank !== 1'b1) begin failures++; $display("FAIL first_edge_blank_n got=%0b exp=1", b_blank); end
    checks++; if (b_ls !== 1'b1 || b_fs !== 1'b1) begin failures++; $display("FAIL first_edge_strobes got=ls%0b fs%0b exp=1 1", b_ls, b_fs); end
    checks++; if (b_hs !== IDLE) begin failures++; $display("FAIL first_edge_hs got=%0b exp=%0b", b_hs, IDLE); end
  endtask

  // Entered just after edge 1 following release; walks edges 1..1600 (two lines).
  task automatic test_two_lines();
    int pos_err = 0;
    int hs_act = 0;
    int first_hs_x = -1;
    int blank_cnt = 0;
    int fs_cnt = 0;
    int fall_k[$];
    int ls_k[$];
    logic prev_hs = IDLE;
    for (int k = 1; k <= 1600; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (b_x !== 11'((k - 1) % 800) || b_y !== 10'((k - 1) / 800)) pos_err++;
      if (b_hs === ACT) begin
        hs_act++;
        if (first_hs_x < 0) first_hs_x = int'(b_x);
        if (prev_hs !== ACT) fall_k.push_back(k);
      end
      if (b_ls === 1'b1) ls_k.push_back(k);
      if (b_fs === 1'b1) fs_cnt++;
      if (b_blank === 1'b1) blank_cnt++;
      prev_hs = b_hs;
    end
    checks++; if (pos_err != 0) begin failures++; $display("FAIL line_xy_sequence got_errors=%0d exp=0", pos_err); end
    checks++; if (hs_act != 192) begin failures++; $display("FAIL hs_active_cycles got=%0d exp=192", hs_act); end
    checks++; if (first_hs_x != 656) begin failures++; $display("FAIL hs_start_x got=%0d exp=656", first_hs_x); end
    checks++; if (fall_k.size() != 2) begin failures++; $display("FAIL hs_edge_count got=%0d exp=2", fall_k.size()); end
    else if (fall_k[1] - fall_k[0] != 800) begin failures++; $display("FAIL hs_period got=%0d exp=800", fall_k[1] - fall_k[0]); end
    checks++; if (ls_k.size() != 2) begin failures++; $display("FAIL line_start_count got=%0d exp=2", ls_k.size()); end
    else if (ls_k[0] != 1 || ls_k[1] != 801) begin failures++; $display("FAIL line_start_cycles got=%0d,%0d exp=1,801", ls_k[0], ls_k[1]); end
    checks++; if (blank_cnt != 1280) begin failures++; $display("FAIL line_blank_n_cycles got=%0d exp=1280", blank_cnt); end
    checks++; if (fs_cnt != 1) begin failures++; $display("FAIL line_frame_start_count got=%0d exp=1", fs_cnt); end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      @(posedge clk); #1;
      if (b_x === 11'd300 && b_y === 10'd2) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL async_reach_300_2 got=(%0d,%0d) exp=(300,2)", b_x, b_y); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (b_x !== 11'd0 || b_y !== 10'd0) begin failures++; $display("FAIL async_xy got=(%0d,%0d) exp=(0,0)", b_x, b_y); end
    checks++; if (b_blank !== 1'b0 || b_hs !== IDLE || b_vs !== IDLE) begin failures++; $display("FAIL async_levels got=b%0b h%0b v%0b exp=0 %0b %0b", b_blank, b_hs, b_vs, IDLE, IDLE); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (b_x !== 11'd0 || b_y !== 10'd0 || b_fs !== 1'b1) begin failures++; $display("FAIL async_restart got=(%0d,%0d) fs%0b exp=(0,0) fs1", b_x, b_y, b_fs); end
    @(posedge clk); #1;
    checks++; if (b_x !== 11'd1 || b_y !== 10'd0) begin failures++; $display("FAIL async_restart_next got=(%0d,%0d) exp=(1,0)", b_x, b_y); end
  endtask

  // Small raster: H_TOTAL=14, V_TOTAL=7, frame = 98 cycles. Sync windows h 10..11, v 5.
  task automatic test_small_frames();
    int pos_err = 0, hs_err = 0, vs_err = 0, ls_err = 0, fs_err = 0;
    int blank_cnt = 0, hs_cnt = 0, vs_cnt = 0;
    int max_x = 0, max_y = 0;
    int wrap_seen = 0, wrap_err = 0;
    int vs_edge_x = -1, vs_edge_y = -1;
    int fs_k[$];
    int eh, ev;
    logic prev_vs = IDLE;
    bit   prev_corner = 1'b0;
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      eh = (k - 1) % 14;
      ev = ((k - 1) / 14) % 7;
      if (s_x !== 11'(eh) || s_y !== 10'(ev)) pos_err++;
      if (s_hs !== ((eh >= 10 && eh <= 11) ? ACT : IDLE)) hs_err++;
      if (s_vs !== ((ev == 5) ? ACT : IDLE)) vs_err++;
      if (s_ls !== (eh == 0)) ls_err++;
      if (s_fs !== (eh == 0 && ev == 0)) fs_err++;
      if (k <= 196) begin
        if (s_blank === 1'b1) blank_cnt++;
        if (s_hs === ACT) hs_cnt++;
        if (s_vs === ACT) vs_cnt++;
      end
      if (int'(s_x) > max_x) max_x = int'(s_x);
      if (int'(s_y) > max_y) max_y = int'(s_y);
      if (s_fs === 1'b1) fs_k.push_back(k);
      if (s_vs === ACT && prev_vs !== ACT && vs_edge_x < 0) begin
        vs_edge_x = int'(s_x);
        vs_edge_y = int'(s_y);
      end
      if (prev_corner) begin
        wrap_seen++;
        if (s_x !== 11'd0 || s_y !== 10'd0 || s_fs !== 1'b1) wrap_err++;
      end
      prev_corner = (s_x === 11'd13 && s_y === 10'd6);
      prev_vs = s_vs;
    end
    checks++; if (pos_err != 0) begin failures++; $display("FAIL small_xy_sequence got_errors=%0d exp=0", pos_err); end
    checks++; if (hs_err != 0) begin failures++; $display("FAIL small_hs_window got_errors=%0d exp=0", hs_err); end
    checks++; if (vs_err != 0) begin failures++; $display("FAIL small_vs_window got_errors=%0d exp=0", vs_err); end
    checks++; if (ls_err != 0 || fs_err != 0) begin failures++; $display("FAIL small_strobes got_errors=ls%0d fs%0d exp=0 0", ls_err, fs_err); end
    checks++; if (blank_cnt != 64) begin failures++; $display("FAIL small_blank_n_cycles got=%0d exp=64", blank_cnt); end
    checks++; if (hs_cnt != 28) begin failures++; $display("FAIL small_hs_cycles got=%0d exp=28", hs_cnt); end
    checks++; if (vs_cnt != 28) begin failures++; $display("FAIL small_vs_cycles got=%0d exp=28", vs_cnt); end
    checks++; if (fs_k.size() != 3) begin failures++; $display("FAIL small_frame_start_count got=%0d exp=3", fs_k.size()); end
    else if (fs_k[0] != 1 || fs_k[1] - fs_k[0] != 98 || fs_k[2] - fs_k[1] != 98) begin
      failures++; $display("FAIL small_frame_period got=%0d,%0d,%0d exp=1,99,197", fs_k[0], fs_k[1], fs_k[2]);
    end
    checks++; if (max_x != 13 || max_y != 6) begin failures++; $display("FAIL small_max_xy got=(%0d,%0d) exp=(13,6)", max_x, max_y); end
    checks++; if (vs_edge_x != 0 || vs_edge_y != 5) begin failures++; $display("FAIL small_vs_edge got=(%0d,%0d) exp=(0,5)", vs_edge_x, vs_edge_y); end
    checks++; if (wrap_seen != 2 || wrap_err != 0) begin failures++; $display("FAIL small_wrap got=seen%0d err%0d exp=seen2 err0", wrap_seen, wrap_err); end
  endtask

  initial begin
    test_reset();
    test_two_lines();
    test_async_reset();
    test_small_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
